axi2iob_bridge: RTL and testbench



---
 rtl/axi2iob_pkg.sv | 16 +
 rtl/axi2iob_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_axi2iob_bridge.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2iob_pkg.sv
// rtl/axi2iob_pkg.sv - shared state encoding and AXI response codes for the AXI-to-IOb bridge
package axi2iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BEAT,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DATA
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi2iob_bridge.sv
// rtl/axi2iob_bridge.sv - AXI4 slave issuing one IOb request per beat, one transaction in flight
// Bursts (len != 0) are served only when AXI2IOB_BURST_EN is defined; otherwise they complete with SLVERR.
module axi2iob_bridge
  import axi2iob_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_LEN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic [AXI_ID_W-1:0]   axi_awid_i,
  input  logic [ADDR_W-1:0]     axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  input  logic [DATA_W-1:0]     axi_wdata_i,
  input  logic [DATA_W/8-1:0]   axi_wstrb_i,
  input  logic                  axi_wlast_i,
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  output logic [AXI_ID_W-1:0]   axi_bid_o,
  output logic [1:0]            axi_bresp_o,
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  input  logic [AXI_ID_W-1:0]   axi_arid_i,
  input  logic [ADDR_W-1:0]     axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  output logic [AXI_ID_W-1:0]   axi_rid_o,
  output logic [DATA_W-1:0]     axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic                  axi_rlast_o,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_rvalid_i,
  input  logic                  iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(STRB_W);

  state_t               state_q, state_d;
  logic                 prio_wr_q, prio_wr_d;
  logic [AXI_ID_W-1:0]  id_q, id_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [AXI_LEN_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 berr_q, berr_d;
  logic                 unsup_q, unsup_d;

  logic grant_wr, grant_rd, cnt_zero, active, aw_unsup, ar_unsup;
  logic aw_hs, ar_hs, w_hs, b_hs, r_hs;

`ifdef AXI2IOB_BURST_EN
  assign aw_unsup = 1'b0;
  assign ar_unsup = 1'b0;
`else
  assign aw_unsup = (axi_awlen_i != '0);
  assign ar_unsup = (axi_arlen_i != '0);
`endif

  // On a tie the channel served last loses; prio_wr_q resets to 1 so write goes first.
  assign grant_wr = axi_awvalid_i & (~axi_arvalid_i | prio_wr_q);
  assign grant_rd = axi_arvalid_i & ~grant_wr;
  assign cnt_zero = (cnt_q == '0);
  assign active   = cke_i & ~rst_i;

  assign aw_hs = axi_awvalid_i & axi_awready_o;
  assign ar_hs = axi_arvalid_i & axi_arready_o;
  assign w_hs  = axi_wvalid_i & axi_wready_o;
  assign b_hs  = axi_bvalid_o & axi_bready_i;
  assign r_hs  = axi_rvalid_o & axi_rready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      berr_q    <= 1'b0;
      unsup_q   <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      berr_q    <= berr_d;
      unsup_q   <= unsup_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    berr_d    = berr_q;
    unsup_d   = unsup_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d      = axi_awid_i;
          addr_d    = axi_awaddr_i;
          cnt_d     = axi_awlen_i;
          berr_d    = aw_unsup;
          unsup_d   = aw_unsup;
          prio_wr_d = 1'b0;
          state_d   = ST_WR_BEAT;
        end else if (ar_hs) begin
          id_d      = axi_arid_i;
          addr_d    = axi_araddr_i;
          cnt_d     = axi_arlen_i;
          rdata_d   = '0;
          berr_d    = 1'b0;
          unsup_d   = ar_unsup;
          prio_wr_d = 1'b1;
          state_d   = ar_unsup ? ST_RD_DATA : ST_RD_REQ;
        end
      end
      ST_WR_BEAT: begin
        if (w_hs) begin
          if (axi_wlast_i != cnt_zero) berr_d = 1'b1;
          if (cnt_zero) begin
            state_d = ST_WR_RESP;
          end else begin
            cnt_d  = cnt_q - AXI_LEN_W'(1);
            addr_d = addr_q + ADDR_INC;
          end
        end
      end
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      ST_RD_REQ:  if (iob_ready_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (iob_rvalid_i) begin
          rdata_d = iob_rdata_i;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_hs) begin
          if (cnt_zero) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - AXI_LEN_W'(1);
            addr_d  = addr_q + ADDR_INC;
            state_d = unsup_q ? ST_RD_DATA : ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs drop while reset is high or the clock is disabled so no transfer is lost.
  always_comb begin
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    iob_avalid_o  = 1'b0;
    iob_wstrb_o   = '0;
    iob_addr_o    = '0;
    iob_wdata_o   = '0;
    axi_bid_o     = '0;
    axi_bresp_o   = AXI_RESP_OKAY;
    axi_rid_o     = '0;
    axi_rdata_o   = '0;
    axi_rresp_o   = AXI_RESP_OKAY;
    axi_rlast_o   = 1'b0;
    if (!rst_i) begin
      iob_addr_o  = addr_q;
      iob_wdata_o = axi_wdata_i;
      axi_bid_o   = id_q;
      axi_rid_o   = id_q;
      axi_rdata_o = rdata_q;
      case (state_q)
        ST_IDLE: begin
          axi_awready_o = active & grant_wr;
          axi_arready_o = active & grant_rd;
        end
        ST_WR_BEAT: begin
          if (unsup_q || axi_wstrb_i == '0) begin
            axi_wready_o = active;
          end else begin
            iob_avalid_o = active & axi_wvalid_i;
            axi_wready_o = active & iob_ready_i;
            iob_wstrb_o  = axi_wstrb_i;
          end
        end
        ST_WR_RESP: begin
          axi_bvalid_o = active;
          axi_bresp_o  = berr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
        ST_RD_REQ: iob_avalid_o = active;
        ST_RD_DATA: begin
          axi_rvalid_o = active;
          axi_rlast_o  = cnt_zero;
          axi_rresp_o  = unsup_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2iob_bridge.sv
// tb/tb_axi2iob_bridge.sv - scoreboard bench for axi2iob_bridge (expectations follow AXI2IOB_BURST_EN)
module tb_axi2iob_bridge;

`ifdef AXI2IOB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk, cke_i, rst_i;
  logic        axi_awid_i, axi_awvalid_i, axi_awready_o;
  logic [31:0] axi_awaddr_i;
  logic [7:0]  axi_awlen_i;
  logic [31:0] axi_wdata_i;
  logic [3:0]  axi_wstrb_i;
  logic        axi_wlast_i, axi_wvalid_i, axi_wready_o;
  logic        axi_bid_o, axi_bvalid_o, axi_bready_i;
  logic [1:0]  axi_bresp_o;
  logic        axi_arid_i, axi_arvalid_i, axi_arready_o;
  logic [31:0] axi_araddr_i;
  logic [7:0]  axi_arlen_i;
  logic        axi_rid_o, axi_rlast_o, axi_rvalid_o, axi_rready_i;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic        iob_avalid_o, iob_rvalid_i, iob_ready_i;
  logic [31:0] iob_addr_o, iob_wdata_o, iob_rdata_i;
  logic [3:0]  iob_wstrb_o;

  axi2iob_bridge dut (
    .clk_i(clk), .cke_i(cke_i), .rst_i(rst_i),
    .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
    .axi_bready_i(axi_bready_i),
    .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_rdata_i(iob_rdata_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i(iob_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } iob_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; bit last; logic id; } r_t;
  typedef struct { logic [1:0] resp; logic id; } b_t;

  iob_t exp_iob[$];
  r_t   exp_r[$];
  b_t   exp_b[$];
  bit   exp_grant[$];

  int n_checks = 0, n_pass = 0;
  int iob_seen = 0, iob_exp_total = 0, avalid_cyc = 0, r_seen = 0;
  int rd_lat = 1;
  bit ready_force = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wd [4];
  logic [3:0]  ws [4];
  bit          wl [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk) begin : mon
    iob_t ie;
    r_t   re;
    b_t   be;
    if (!rst_i) begin
      if (iob_avalid_o) avalid_cyc++;
      if (iob_avalid_o && iob_ready_i) begin
        iob_seen++;
        if (exp_iob.size() == 0) chk("iob_unexpected", 1, 0);
        else begin
          ie = exp_iob.pop_front();
          chk("iob_we", 64'(iob_wstrb_o != 0), 64'(ie.we));
          chk("iob_addr", iob_addr_o, ie.addr);
          if (ie.we) begin
            chk("iob_wdata", iob_wdata_o, ie.data);
            chk("iob_wstrb", iob_wstrb_o, ie.strb);
          end
        end
      end
      if (axi_rvalid_o && axi_rready_i) begin
        r_seen++;
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          re = exp_r.pop_front();
          chk("r_data", axi_rdata_o, re.data);
          chk("r_resp", axi_rresp_o, re.resp);
          chk("r_last", axi_rlast_o, re.last);
          chk("r_id", axi_rid_o, re.id);
        end
      end
      if (axi_bvalid_o && axi_bready_i) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          be = exp_b.pop_front();
          chk("b_resp", axi_bresp_o, be.resp);
          chk("b_id", axi_bid_o, be.id);
        end
      end
      if (((axi_awvalid_i && axi_awready_o) || (axi_arvalid_i && axi_arready_o)) && exp_grant.size() > 0)
        chk("grant_is_write", axi_awready_o, exp_grant.pop_front());
    end
  end

  initial begin : slave
    int rd_cnt;
    logic [31:0] rd_q;
    rd_cnt = 0;
    rd_q = '0;
    iob_ready_i = 1'b0;
    iob_rvalid_i = 1'b0;
    iob_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_i && iob_avalid_o && iob_ready_i && iob_wstrb_o == 4'h0) begin
        rd_cnt = rd_lat;
        rd_q = mem_rd(iob_addr_o);
      end
      @(posedge clk);
      #1;
      iob_rvalid_i = 1'b0;
      iob_rdata_i = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          iob_rvalid_i = 1'b1;
          iob_rdata_i = rd_q;
        end
      end
      iob_ready_i = ready_force ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int which, input string tag);
    bit ok;
    int t;
    ok = 1'b0;
    t = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      case (which)
        0: ok = axi_awready_o;
        1: ok = axi_wready_o;
        2: ok = axi_bvalid_o;
        default: ok = axi_arready_o;
      endcase
      tick();
      t++;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic exp_write(input logic id, input logic [31:0] addr, input int len);
    iob_t e;
    b_t b;
    bit err;
    err = (!BURST && len != 0);
    for (int k = 0; k <= len; k++) begin
      if (wl[k] != (k == len)) err = 1'b1;
      if ((BURST || len == 0) && ws[k] != 4'h0) begin
        e.we = 1'b1; e.addr = addr + 32'(4 * k); e.data = wd[k]; e.strb = ws[k];
        exp_iob.push_back(e);
        iob_exp_total++;
      end
    end
    b.id = id;
    b.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(b);
  endtask

  task automatic exp_read(input logic id, input logic [31:0] addr, input int len);
    iob_t e;
    r_t r;
    for (int k = 0; k <= len; k++) begin
      if (BURST || len == 0) begin
        e.we = 1'b0; e.addr = addr + 32'(4 * k); e.data = '0; e.strb = '0;
        exp_iob.push_back(e);
        iob_exp_total++;
        r.data = mem_rd(addr + 32'(4 * k));
        r.resp = 2'b00;
      end else begin
        r.data = '0;
        r.resp = 2'b10;
      end
      r.last = (k == len);
      r.id = id;
      exp_r.push_back(r);
    end
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input bit l);
    axi_wdata_i = d; axi_wstrb_i = s; axi_wlast_i = l; axi_wvalid_i = 1'b1;
    wait_hs(1, "w");
    axi_wvalid_i = 1'b0;
  endtask

  task automatic b_take();
    axi_bready_i = 1'b1;
    wait_hs(2, "b");
    axi_bready_i = 1'b0;
  endtask

  task automatic r_take(input int n);
    int got, t;
    got = 0;
    t = 0;
    while (got < n && t < 600) begin
      axi_rready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (axi_rvalid_o && axi_rready_i) got++;
      tick();
      t++;
    end
    axi_rready_i = 1'b0;
    if (got < n) chk("r_timeout", got, n);
  endtask

  task automatic do_write(input logic id, input logic [31:0] addr, input int len);
    exp_write(id, addr, len);
    axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = 8'(len); axi_awvalid_i = 1'b1;
    wait_hs(0, "aw");
    axi_awvalid_i = 1'b0;
    for (int k = 0; k <= len; k++) w_beat(wd[k], ws[k], wl[k]);
    b_take();
  endtask

  task automatic do_read(input logic id, input logic [31:0] addr, input int len);
    exp_read(id, addr, len);
    axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = 8'(len); axi_arvalid_i = 1'b1;
    wait_hs(3, "ar");
    axi_arvalid_i = 1'b0;
    r_take(len + 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_hs"}, {axi_awready_o, axi_wready_o, axi_bvalid_o, axi_arready_o, axi_rvalid_o, iob_avalid_o}, 0);
    chk({tag, "_data"}, 64'(|{iob_addr_o, iob_wdata_o, iob_wstrb_o, axi_rdata_o, axi_rresp_o,
                              axi_bresp_o, axi_rlast_o, axi_bid_o, axi_rid_o}), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int s0, a0, r0, nw, nr, t;
    bit is_wr;
    logic [31:0] gd [2];
    cke_i = 1'b1; rst_i = 1'b1;
    axi_awid_i = 1'b0; axi_awaddr_i = 32'h300; axi_awlen_i = '0; axi_awvalid_i = 1'b1;
    axi_arid_i = 1'b1; axi_araddr_i = 32'h380; axi_arlen_i = '0; axi_arvalid_i = 1'b1;
    axi_wdata_i = 32'hFFFF_FFFF; axi_wstrb_i = 4'hF; axi_wlast_i = 1'b1; axi_wvalid_i = 1'b1;
    axi_bready_i = 1'b1; axi_rready_i = 1'b1;
    mem[32'h200] = 32'h11; mem[32'h204] = 32'h22; mem[32'h208] = 32'h33; mem[32'h20C] = 32'h44;

    repeat (3) tick();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    axi_wvalid_i = 1'b0; axi_bready_i = 1'b0; axi_rready_i = 1'b0;

    // Both address channels held valid for two rounds: write, read, write, read.
    gd[0] = 32'hA000_0001; gd[1] = 32'hA000_0002;
    ws[0] = 4'hF; wl[0] = 1'b1;
    wd[0] = gd[0]; exp_write(0, 32'h300, 0); exp_read(1, 32'h380, 0);
    wd[0] = gd[1]; exp_write(0, 32'h300, 0); exp_read(1, 32'h380, 0);
    exp_grant.push_back(1); exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(0);
    rst_i = 1'b0;
    nw = 0; nr = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      is_wr = 1'b0;
      forever begin
        @(negedge clk);
        if (axi_awready_o || axi_arready_o || t >= 100) break;
        t++;
      end
      if (!axi_awready_o && !axi_arready_o) begin
        chk("grant_timeout", 0, 1);
        tick();
        break;
      end
      is_wr = axi_awready_o;
      tick();
      if (is_wr) begin
        axi_awvalid_i = 1'b0;
        w_beat(gd[nw % 2], 4'hF, 1'b1);
        b_take();
        nw++;
        if (nw < 2) axi_awvalid_i = 1'b1;
      end else begin
        axi_arvalid_i = 1'b0;
        r_take(1);
        nr++;
        if (nr < 2) axi_arvalid_i = 1'b1;
      end
    end
    axi_awvalid_i = 1'b0; axi_arvalid_i = 1'b0;
    chk("grant_all_popped", exp_grant.size(), 0);

    wd[0] = 32'hCAFE_BABE; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(1, 32'h100, 0);

    s0 = iob_seen; a0 = avalid_cyc;
    do_read(0, 32'h200, 3);
    chk("rd_burst_iob", BURST ? iob_seen - s0 : avalid_cyc - a0, BURST ? 4 : 0);

    wd[0] = 32'h1111_0001; ws[0] = 4'hF; wl[0] = 1'b1;
    wd[1] = 32'h2222_0002; ws[1] = 4'hF; wl[1] = 1'b1;
    do_write(0, 32'h600, 1);

    // Wraps past the top of the address space; the middle beat has no strobes.
    wd[0] = 32'h3333_0003; ws[0] = 4'hF; wl[0] = 1'b0;
    wd[1] = 32'h4444_0004; ws[1] = 4'h0; wl[1] = 1'b0;
    wd[2] = 32'h5555_0005; ws[2] = 4'h3; wl[2] = 1'b1;
    do_write(1, 32'hFFFF_FFF8, 2);

    ready_force = 1'b1; rd_lat = 6;
    if (BURST) begin
      exp_iob.push_back('{we: 1'b0, addr: 32'h400, data: 32'h0, strb: 4'h0});
      iob_exp_total++;
    end
    axi_arid_i = 1'b0; axi_araddr_i = 32'h400; axi_arlen_i = 8'd2; axi_arvalid_i = 1'b1;
    wait_hs(3, "ar_rst");
    axi_arvalid_i = 1'b0;
    tick();
    rst_i = 1'b1; axi_wdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_quiet("midrst1");
    tick();
    @(negedge clk);
    chk_quiet("midrst2");
    tick();
    rst_i = 1'b0;
    r0 = r_seen;
    axi_rready_i = 1'b1;
    repeat (12) tick();
    axi_rready_i = 1'b0;
    chk("rst_no_r_beat", r_seen - r0, 0);
    ready_force = 1'b0; rd_lat = 1;
    do_read(1, 32'h500, 0);

    repeat (4) tick();
    chk("iob_total", iob_seen, iob_exp_total);
    chk("sb_empty", exp_iob.size() + exp_r.size() + exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
